// File: rtl/braille_switch_capture.sv
// braille_switch_capture
// Synchronizes and debounces six raw Braille dot switches and a submit
// button, then captures the debounced dot pattern on each button press and
// holds it, with a valid flag, until the downstream decoder acknowledges it.
//
// Optional feature macro: BRAILLE_BLANK_REJECT_EN
//   defined   -> a press with an all-zero (blank) pattern is not captured;
//                the FSM waits for the button release instead.
//   undefined -> the blank pattern is captured like any other pattern.
//
// Debounce timing: a debounced value changes once its synchronized input has
// been stable for DEB_CYCLES cycles. The counter loads on the edge where it
// would reach DEB_CYCLES-1, so a button held from edge 0 raises valid on
// edge DEB_CYCLES+2.

module braille_switch_capture #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] switch_raw,
  input  logic       enter_raw,
  input  logic       ack,
  output logic [5:0] switch,
  output logic       valid,
  output logic       busy
);

  // Counter value on which the next stable cycle completes the debounce
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    HOLD         = 2'b01,
    WAIT_RELEASE = 2'b10
  } state_t;

  // Synchronizer and debounce state
  logic [5:0]       sw_s1_r;
  logic [5:0]       sw_s2_r;
  logic [5:0]       sw_s2_prev_r;
  logic [5:0]       sw_db_r;
  logic [CNT_W-1:0] sw_cnt_r;
  logic             en_s1_r;
  logic             en_s2_r;
  logic             en_s2_prev_r;
  logic             en_db_r;
  logic             en_db_prev_r;
  logic [CNT_W-1:0] en_cnt_r;

  // Debounce next-state values
  logic [5:0]       sw_db_s;
  logic [CNT_W-1:0] sw_cnt_s;
  logic             en_db_s;
  logic [CNT_W-1:0] en_cnt_s;

  // Capture FSM and registered outputs
  state_t           state_r;
  state_t           state_s;
  logic [5:0]       switch_r;
  logic [5:0]       switch_s;
  logic             valid_r;
  logic             valid_s;
  logic             busy_r;
  logic             busy_s;
  logic             press_s;

  // Two-flop synchronizers plus the previous-cycle copy used for stability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_r      <= 6'b000000;
      sw_s2_r      <= 6'b000000;
      sw_s2_prev_r <= 6'b000000;
      en_s1_r      <= 1'b0;
      en_s2_r      <= 1'b0;
      en_s2_prev_r <= 1'b0;
    end else begin
      sw_s1_r      <= switch_raw;
      sw_s2_r      <= sw_s1_r;
      sw_s2_prev_r <= sw_s2_r;
      en_s1_r      <= enter_raw;
      en_s2_r      <= en_s1_r;
      en_s2_prev_r <= en_s2_r;
    end
  end

  // Vector-wide switch debounce: any bit moving restarts the count
  always_comb begin
    sw_db_s  = sw_db_r;
    sw_cnt_s = sw_cnt_r;
    if (sw_s2_r != sw_s2_prev_r) begin
      sw_cnt_s = CNT_ZERO;
    end else if (sw_s2_r != sw_db_r) begin
      if (sw_cnt_r == CNT_LOAD) begin
        sw_db_s  = sw_s2_r;
        sw_cnt_s = CNT_ZERO;
      end else begin
        sw_cnt_s = sw_cnt_r + CNT_ONE;
      end
    end else begin
      sw_cnt_s = CNT_ZERO;
    end
  end

  // Enter button debounce, same scheme on its own counter
  always_comb begin
    en_db_s  = en_db_r;
    en_cnt_s = en_cnt_r;
    if (en_s2_r != en_s2_prev_r) begin
      en_cnt_s = CNT_ZERO;
    end else if (en_s2_r != en_db_r) begin
      if (en_cnt_r == CNT_LOAD) begin
        en_db_s  = en_s2_r;
        en_cnt_s = CNT_ZERO;
      end else begin
        en_cnt_s = en_cnt_r + CNT_ONE;
      end
    end else begin
      en_cnt_s = CNT_ZERO;
    end
  end

  // Debounced values, counters and the edge-detect history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_db_r      <= 6'b000000;
      sw_cnt_r     <= CNT_ZERO;
      en_db_r      <= 1'b0;
      en_cnt_r     <= CNT_ZERO;
      en_db_prev_r <= 1'b0;
    end else begin
      sw_db_r      <= sw_db_s;
      sw_cnt_r     <= sw_cnt_s;
      en_db_r      <= en_db_s;
      en_cnt_r     <= en_cnt_s;
      en_db_prev_r <= en_db_r;
    end
  end

  // A press is the rising edge of the debounced enter button
  assign press_s = en_db_r & ~en_db_prev_r;

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      switch_r <= 6'b000000;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      switch_r <= switch_s;
      valid_r  <= valid_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state and next-output logic; presses outside IDLE are dropped
  always_comb begin
    state_s  = state_r;
    switch_s = switch_r;
    valid_s  = valid_r;
    busy_s   = busy_r;
    case (state_r)
      IDLE: begin
        if (press_s) begin
`ifdef BRAILLE_BLANK_REJECT_EN
          if (sw_db_r == 6'b000000) begin
            state_s = WAIT_RELEASE;
            valid_s = 1'b0;
            busy_s  = 1'b1;
          end else begin
            state_s  = HOLD;
            switch_s = sw_db_r;
            valid_s  = 1'b1;
            busy_s   = 1'b1;
          end
`else
          state_s  = HOLD;
          switch_s = sw_db_r;
          valid_s  = 1'b1;
          busy_s   = 1'b1;
`endif
        end else begin
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      HOLD: begin
        if (ack) begin
          valid_s = 1'b0;
          if (en_db_r) begin
            state_s = WAIT_RELEASE;
            busy_s  = 1'b1;
          end else begin
            state_s = IDLE;
            busy_s  = 1'b0;
          end
        end else begin
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        valid_s = 1'b0;
        if (!en_db_r) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign switch = switch_r;
  assign valid  = valid_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_braille_switch_capture.sv
// Bench for braille_switch_capture with DEB_CYCLES=4. Expected capture
// patterns are queued when a press is driven and popped by a monitor on
// every valid rising edge.

module tb_braille_switch_capture;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] switch_raw;
  logic       enter_raw;
  logic       ack;
  logic [5:0] switch;
  logic       valid;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;
  logic [5:0] last_cap = 6'b000000;
  logic       valid_seen = 1'b0;

  braille_switch_capture #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch_raw(switch_raw),
    .enter_raw (enter_raw),
    .ack       (ack),
    .switch    (switch),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: each valid rising edge must match a queued capture
  initial begin
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && valid_seen !== 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_valid: valid=1 switch=%b, required no capture", switch);
        end else begin
          mon_exp = exp_q.pop_front();
          last_cap = mon_exp;
          if (switch !== mon_exp) begin
            miscompares++;
            $display("FAIL capture_pattern: switch=%b, required %b", switch, mon_exp);
          end
        end
      end
      valid_seen = valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    ok = (valid === 1'b1);
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    switch_raw = 6'b101010;
    enter_raw = 1'b0;
    ack = 1'b0;
    #2;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", valid); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++;
    if (switch !== 6'b000000) begin miscompares++; $display("FAIL reset_switch: got %b, required 000000", switch); end
    @(negedge clk);
    tickn(2);
    vectors++;
    if (valid !== 1'b0 || switch !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_held: valid=%b switch=%b, required 0 000000", valid, switch);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    bit ok;
    switch_raw = 6'b000101;
    tickn(10);
    enter_raw = 1'b1;
    exp_q.push_back(6'b000101);
    for (int i = 0; i <= DEB + 2; i++) begin
      tick();
      vectors++;
      if (valid !== (i == DEB + 2)) begin
        miscompares++;
        $display("FAIL latency_edge%0d: valid=%b, required %b", i, valid, (i == DEB + 2));
      end
    end
    vectors++;
    if (switch !== 6'b000101 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL capture_outputs: switch=%b busy=%b, required 000101 1", switch, busy);
    end
    pulse_ack();
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_clear: valid=%b busy=%b, required 0 1", valid, busy);
    end
    enter_raw = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL release_idle: busy=%b, required 0 within 40 cycles", busy); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      enter_raw = ((i % 4) < 2);
      tick();
      vectors++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_cycle%0d: valid=%b busy=%b, required 0 0", i, valid, busy);
      end
    end
    enter_raw = 1'b0;
    tickn(10);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_settle: valid=%b busy=%b, required 0 0", valid, busy);
    end
    pulse_ack();
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack: valid=%b busy=%b, required 0 0", valid, busy);
    end
  endtask

  task automatic test_hold_release();
    bit ok;
    switch_raw = 6'b001011;
    tickn(8);
    enter_raw = 1'b1;
    exp_q.push_back(6'b001011);
    wait_valid(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL hold_timeout: valid=%b, required 1", valid); end
    switch_raw = 6'b110001;
    tickn(10);
    vectors++;
    if (switch !== 6'b001011 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_stable: switch=%b valid=%b, required 001011 1", switch, valid);
    end
    pulse_ack();
    vectors++;
    if (switch !== 6'b001011 || valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_release: switch=%b valid=%b busy=%b, required 001011 0 1", switch, valid, busy);
    end
    tickn(10);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_held: valid=%b busy=%b, required 0 1", valid, busy);
    end
    enter_raw = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wait_exit: busy=%b, required 0", busy); end
    enter_raw = 1'b1;
    exp_q.push_back(6'b110001);
    wait_valid(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL repress_timeout: valid=%b, required 1", valid); end
    pulse_ack();
    enter_raw = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL repress_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_hold_discard();
    bit ok;
    switch_raw = 6'b100110;
    tickn(8);
    enter_raw = 1'b1;
    exp_q.push_back(6'b100110);
    wait_valid(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL discard_timeout: valid=%b, required 1", valid); end
    enter_raw = 1'b0;
    tickn(10);
    enter_raw = 1'b1;
    tickn(10);
    enter_raw = 1'b0;
    tickn(10);
    vectors++;
    if (valid !== 1'b1 || switch !== 6'b100110) begin
      miscompares++;
      $display("FAIL discard_hold: valid=%b switch=%b, required 1 100110", valid, switch);
    end
    pulse_ack();
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL discard_ack: valid=%b busy=%b, required 0 0", valid, busy);
    end
    tickn(10);
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL discard_queued: valid=%b, required 0", valid); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [5:0] pats[4];
    pats[0] = 6'b100000;
    pats[1] = 6'b011111;
    pats[2] = 6'b101101;
    pats[3] = 6'b000001;
    for (int k = 0; k < 4; k++) begin
      switch_raw = pats[k];
      tickn(8);
      enter_raw = 1'b1;
      exp_q.push_back(pats[k]);
      wait_valid(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL b2b%0d_timeout: valid=%b, required 1", k, valid); end
      pulse_ack();
      enter_raw = 1'b0;
      wait_idle(ok);
      vectors++;
      if (!ok || valid !== 1'b0 || switch !== pats[k]) begin
        miscompares++;
        $display("FAIL b2b%0d_idle: busy=%b valid=%b switch=%b, required 0 0 %b", k, busy, valid, switch, pats[k]);
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    logic [5:0] prev_cap;
    prev_cap = last_cap;
    switch_raw = 6'b000000;
    tickn(10);
    enter_raw = 1'b1;
`ifdef BRAILLE_BLANK_REJECT_EN
    tickn(12);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1 || switch !== prev_cap) begin
      miscompares++;
      $display("FAIL blank_reject: valid=%b busy=%b switch=%b, required 0 1 %b", valid, busy, switch, prev_cap);
    end
    enter_raw = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL blank_release: busy=%b, required 0", busy); end
`else
    exp_q.push_back(6'b000000);
    wait_valid(ok);
    vectors++;
    if (!ok || switch !== 6'b000000 || prev_cap === 6'b000000) begin
      miscompares++;
      $display("FAIL blank_capture: valid=%b switch=%b, required 1 000000 after nonzero", valid, switch);
    end
    pulse_ack();
    enter_raw = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL blank_idle: busy=%b, required 0", busy); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    switch_raw = 6'b111111;
    tickn(8);
    enter_raw = 1'b1;
    exp_q.push_back(6'b111111);
    wait_valid(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL mid_timeout: valid=%b, required 1", valid); end
    rst_n = 1'b0;
    enter_raw = 1'b0;
    #1;
    last_cap = 6'b000000;
    vectors++;
    if (valid !== 1'b0 || switch !== 6'b000000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b switch=%b busy=%b, required 0 000000 0", valid, switch, busy);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      vectors++;
      if (valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_quiet%0d: valid=%b, required 0", i, valid);
      end
    end
    // Enter held through a reset must yield exactly one capture after release
    switch_raw = 6'b010010;
    enter_raw = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(6'b010010);
    wait_valid(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL held_enter_timeout: valid=%b, required 1", valid); end
    pulse_ack();
    enter_raw = 1'b0;
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL held_enter_idle: busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bounce();
    test_hold_release();
    test_hold_discard();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    tickn(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_captures: %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/braille_switch_capture.md
BRAILLE_SWITCH_CAPTURE -- requirements
Module: braille_switch_capture

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required before a debounced value changes; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: width of each debounce counter; SHALL satisfy 2^CNT_W > DEB_CYCLES.
REQ-003 Clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 Rst_n  input  1: asynchronous, active-low reset.
REQ-005 Switch_raw  input  6: raw Braille dot switches, asynchronous, bit0=dot1 .. bit5=dot6.
REQ-006 Enter_raw  input  1: raw submit button, asynchronous, active high.
REQ-007 Ack  input  1: downstream consumed the captured pattern; synchronous to Clk.
REQ-008 Switch  output  6: captured pattern, the Switch input of the Braille-to-letter decoder.
REQ-009 Valid  output  1: Switch holds a captured pattern not yet acknowledged.
REQ-010 Busy  output  1: high in HOLD and WAIT_RELEASE, meaning a new press is not accepted.

Function
REQ-011 Switch_raw and Enter_raw SHALL each pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Switch debounce, vector-wide:
- if s2 differs from its previous-cycle value, the counter clears;
- else if s2 differs from sw_db, the counter increments;
- when the counter reaches DEB_CYCLES-1 with s2 still differing, sw_db loads s2 and the counter clears;
- if s2 equals sw_db, the counter clears.
REQ-013 Enter debounce SHALL use the same scheme on its own counter, producing en_db.
REQ-014 A press event is an en_db rising edge, detected against a registered en_db_prev.
REQ-015 The FSM SHALL have states IDLE, HOLD and WAIT_RELEASE.
REQ-016 In IDLE, a press event SHALL load Switch with sw_db, set Valid=1 and move to HOLD on the same edge.
REQ-017 Latency: with both inputs held stable, Valid SHALL rise exactly DEB_CYCLES+2 edges after the first edge that samples Enter_raw high.
REQ-018 In HOLD, Switch and Valid SHALL hold regardless of switch activity.
REQ-019 In HOLD, Ack=1 SHALL clear Valid on the next edge; the FSM then goes to WAIT_RELEASE if en_db=1, else to IDLE.
REQ-020 In WAIT_RELEASE, the FSM SHALL return to IDLE when en_db=0; press events in this state are discarded.
REQ-021 A press event in HOLD SHALL be discarded and never queued, so at most one capture is outstanding.
REQ-022 Ack while Valid=0 SHALL be ignored.
REQ-023 Switch SHALL retain the last captured value after Ack until the next capture.
REQ-024 Busy SHALL be 0 in IDLE and 1 otherwise; Valid SHALL be 1 only in HOLD.

Reset
REQ-025 Rst_n=0 SHALL immediately force Switch=6'b000000, Valid=0, Busy=0, state=IDLE, all synchronizer flops, sw_db and en_db to 0, and both counters to 0.
REQ-026 Reset mid-operation (any state, including Valid=1) SHALL drop the pending capture without any Valid pulse; after release the block behaves as from power-up.
REQ-027 After reset release, an Enter_raw already held high SHALL produce one press event once debounced.

Configuration
REQ-028 Macro BRAILLE_BLANK_REJECT_EN, defined:
- a press event in IDLE with sw_db=6'b000000 SHALL NOT capture;
- Valid stays 0 and Switch is unchanged;
- the FSM goes directly to WAIT_RELEASE.
REQ-029 Macro BRAILLE_BLANK_REJECT_EN, undefined: the all-zero pattern is captured like any other pattern.

Verification (DEB_CYCLES=4)
REQ-030 Switch_raw=6'b000101 stable, Enter_raw rises at edge 0 -> Valid=1 and Switch=6'b000101 after edge 6; Ack pulsed 1 cycle -> Valid=0 next edge.
REQ-031 Enter_raw toggles every 2 cycles for 20 cycles, then stays low -> Valid stays 0 throughout.
REQ-032 Capture 6'b001011 and hold Enter_raw high; change Switch_raw to 6'b110001; pulse Ack -> Switch stays 6'b001011, FSM in WAIT_RELEASE; second capture only after a release and re-press.
REQ-033 Rst_n low for 1 cycle while Valid=1 -> Valid=0 and Switch=6'b000000 immediately, with no spurious Valid afterwards.
REQ-034 Switch_raw=6'b000000 with a press -> Valid=1 and Switch=6'b000000 without BRAILLE_BLANK_REJECT_EN; Valid stays 0 and Busy=1 until release with it.
